ascii_to_scancode: RTL
======================

ASCII_TO_SCANCODE -- requirements
Module: ascii_to_scancode

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: clrn  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: in_ascii  input  8  character to type.
REQ-004 SHALL have port: in_valid  input  1  in_ascii valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a character.
REQ-006 SHALL have port: capslock  input  1  caps-lock state of the emulated keyboard.
REQ-007 SHALL have port: out_byte  output  8  PS/2 set-2 scan-code byte.
REQ-008 SHALL have port: out_valid  output  1  out_byte valid.
REQ-009 SHALL have port: out_ready  input  1  downstream PS/2 transmitter accepts out_byte.
REQ-010 SHALL have port: busy  output  1  a character sequence is in progress.
REQ-011 SHALL have port: err  output  1  one-cycle pulse: the accepted character is unsupported.

Function
REQ-012 SHALL map each character to a base key code:
- letters a-z/A-Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A
- digits 0-9: 45 16 1E 26 25 2E 36 3D 3E 46
- space 29, 0x0D 5A, 0x08 66, 0x09 0D
- ` 0E, - 4E, = 55, [ 54, ] 5B, \ 5D, ; 4C, ' 52, , 41, . 49, / 4A
- shifted symbols ~!@#$%^&*()_+{}|:"<>? use the base code of their unshifted key (US layout).
REQ-013 SHALL compute need_shift = (letter AND (uppercase XOR capslock)) OR (shifted symbol); all other supported characters need_shift=0.
REQ-014 SHALL accept a character when in_valid AND in_ready; sample in_ascii and capslock only in that cycle.
REQ-015 SHALL drive in_ready = 1 only in state IDLE.
REQ-016 SHALL implement FSM: IDLE, SH_MK, KEY_MK, KEY_F0, KEY_BRK, SH_F0, SH_BRK.
REQ-017 SHALL, on acceptance of a supported character, go to SH_MK if need_shift, else KEY_MK.
REQ-018 SHALL drive out_byte by state: SH_MK 12, KEY_MK code, KEY_F0 F0, KEY_BRK code, SH_F0 F0, SH_BRK 12.
REQ-019 SHALL assert out_valid in every non-IDLE state.
REQ-020 SHALL advance state only on out_valid AND out_ready, in the order SH_MK -> KEY_MK -> KEY_F0 -> KEY_BRK; then SH_F0 -> SH_BRK -> IDLE if shifted, else IDLE.
REQ-021 SHALL hold out_byte and out_valid stable while out_ready=0.
REQ-022 SHALL present the first byte (out_valid=1) in the cycle after acceptance.
REQ-023 SHALL return to IDLE in the cycle after the final handshake, so in_ready is high in the next cycle; acceptance and a final-byte handshake never occur in the same cycle.
REQ-024 SHALL emit 3 bytes for unshifted and 6 bytes for shifted characters.
REQ-025 SHALL, on acceptance of an unsupported character, pulse err for exactly one cycle (the next cycle), emit no bytes, and remain in IDLE.
REQ-026 SHALL keep busy = NOT IDLE.
REQ-027 SHALL ignore changes of capslock or in_ascii during a sequence.

Reset
REQ-028 SHALL, while clrn=0, force state IDLE, out_valid=0, out_byte=00, err=0, busy=0, in_ready=0; in_ready returns to 1 in the first cycle after clrn rises.
REQ-029 SHALL abandon any in-progress sequence on reset with no further bytes emitted, even if mid-sequence after a make code.

Verification
REQ-030 SHALL cover: 'a' (61), capslock=0, out_ready=1 -> bytes 1C F0 1C; in_ready high again 4 cycles after acceptance.
REQ-031 SHALL cover: 'A' (41), capslock=0 -> 12 1C F0 1C F0 12; 'A' with capslock=1 -> 1C F0 1C.
REQ-032 SHALL cover: '!' (21) with capslock=1 -> 12 16 F0 16 F0 12; '1' (31) -> 16 F0 16.
REQ-033 SHALL cover: '/' (2F) with out_ready low for 5 cycles on each byte -> 4A F0 4A, each byte held stable; busy=1 throughout.
REQ-034 SHALL cover: 0x80 accepted -> err=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-035 SHALL cover: clrn pulsed low after 12 1C of 'A' -> out_valid=0 immediately; after release 'b' (62) -> 32 F0 32.

Source files
------------

// File: rtl/ascii_to_scancode.sv
// ascii_to_scancode
//   Turns one ASCII character into the PS/2 scan-code set-2 byte stream that a
//   keyboard would send when the character is typed. The sequence is:
//     [12]  code  F0 code  [F0 12]
//   The bracketed left-shift make/break bytes are sent only when the character
//   needs shift.
//
// Ports
//   clk        in   1  clock; all state changes on the rising edge
//   clrn       in   1  asynchronous active-low reset
//   in_ascii   in   8  character to type
//   in_valid   in   1  in_ascii valid
//   in_ready   out  1  high only while idle; a character is taken on in_valid & in_ready
//   capslock   in   1  caps-lock state, sampled together with the character
//   out_byte   out  8  scan-code byte (registered)
//   out_valid  out  1  out_byte valid (registered); high in every non-idle state
//   out_ready  in   1  downstream transmitter takes out_byte
//   busy       out  1  a byte sequence is in progress
//   err        out  1  one-cycle pulse after an unsupported character is taken
module ascii_to_scancode (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] in_ascii,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       capslock,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    localparam logic [7:0] SC_SHIFT = 8'h12;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SH_MK   = 3'd1,
        KEY_MK  = 3'd2,
        KEY_F0  = 3'd3,
        KEY_BRK = 3'd4,
        SH_F0   = 3'd5,
        SH_BRK  = 3'd6
    } state_t;

    typedef struct packed {
        logic       ok;
        logic       shift;
        logic [7:0] code;
    } dec_t;

    // Set-2 make code of a letter key, indexed by the lowercase character.
    function automatic logic [7:0] letter_code(input logic [7:0] lc);
        logic [7:0] c;
        c = 8'h00;
        case (lc)
            8'h61: c = 8'h1C; 8'h62: c = 8'h32; 8'h63: c = 8'h21; 8'h64: c = 8'h23;
            8'h65: c = 8'h24; 8'h66: c = 8'h2B; 8'h67: c = 8'h34; 8'h68: c = 8'h33;
            8'h69: c = 8'h43; 8'h6A: c = 8'h3B; 8'h6B: c = 8'h42; 8'h6C: c = 8'h4B;
            8'h6D: c = 8'h3A; 8'h6E: c = 8'h31; 8'h6F: c = 8'h44; 8'h70: c = 8'h4D;
            8'h71: c = 8'h15; 8'h72: c = 8'h2D; 8'h73: c = 8'h1B; 8'h74: c = 8'h2C;
            8'h75: c = 8'h3C; 8'h76: c = 8'h2A; 8'h77: c = 8'h1D; 8'h78: c = 8'h22;
            8'h79: c = 8'h35; 8'h7A: c = 8'h1A;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Character -> {supported, needs shift, base key code}. Shifted symbols
    // reuse the code of the key they share on a US layout.
    function automatic dec_t decode(input logic [7:0] ch, input logic caps);
        dec_t d;
        logic is_letter;
        logic is_upper;
        d         = '0;
        is_upper  = (ch >= 8'h41) && (ch <= 8'h5A);
        is_letter = is_upper || ((ch >= 8'h61) && (ch <= 8'h7A));
        if (is_letter) begin
            d.ok    = 1'b1;
            d.shift = is_upper ^ caps;
            d.code  = letter_code(ch | 8'h20);
        end else begin
            d.ok = 1'b1;
            case (ch)
                // digits
                8'h30: d.code = 8'h45; 8'h31: d.code = 8'h16; 8'h32: d.code = 8'h1E;
                8'h33: d.code = 8'h26; 8'h34: d.code = 8'h25; 8'h35: d.code = 8'h2E;
                8'h36: d.code = 8'h36; 8'h37: d.code = 8'h3D; 8'h38: d.code = 8'h3E;
                8'h39: d.code = 8'h46;
                // whitespace / control
                8'h20: d.code = 8'h29; 8'h0D: d.code = 8'h5A;
                8'h08: d.code = 8'h66; 8'h09: d.code = 8'h0D;
                // unshifted punctuation  ` - = [ ] \ ; ' , . /
                8'h60: d.code = 8'h0E; 8'h2D: d.code = 8'h4E; 8'h3D: d.code = 8'h55;
                8'h5B: d.code = 8'h54; 8'h5D: d.code = 8'h5B; 8'h5C: d.code = 8'h5D;
                8'h3B: d.code = 8'h4C; 8'h27: d.code = 8'h52; 8'h2C: d.code = 8'h41;
                8'h2E: d.code = 8'h49; 8'h2F: d.code = 8'h4A;
                // shifted symbols  ~ ! @ # $ % ^ & * ( ) _ + { } | : " < > ?
                8'h7E: begin d.code = 8'h0E; d.shift = 1'b1; end
                8'h21: begin d.code = 8'h16; d.shift = 1'b1; end
                8'h40: begin d.code = 8'h1E; d.shift = 1'b1; end
                8'h23: begin d.code = 8'h26; d.shift = 1'b1; end
                8'h24: begin d.code = 8'h25; d.shift = 1'b1; end
                8'h25: begin d.code = 8'h2E; d.shift = 1'b1; end
                8'h5E: begin d.code = 8'h36; d.shift = 1'b1; end
                8'h26: begin d.code = 8'h3D; d.shift = 1'b1; end
                8'h2A: begin d.code = 8'h3E; d.shift = 1'b1; end
                8'h28: begin d.code = 8'h46; d.shift = 1'b1; end
                8'h29: begin d.code = 8'h45; d.shift = 1'b1; end
                8'h5F: begin d.code = 8'h4E; d.shift = 1'b1; end
                8'h2B: begin d.code = 8'h55; d.shift = 1'b1; end
                8'h7B: begin d.code = 8'h54; d.shift = 1'b1; end
                8'h7D: begin d.code = 8'h5B; d.shift = 1'b1; end
                8'h7C: begin d.code = 8'h5D; d.shift = 1'b1; end
                8'h3A: begin d.code = 8'h4C; d.shift = 1'b1; end
                8'h22: begin d.code = 8'h52; d.shift = 1'b1; end
                8'h3C: begin d.code = 8'h41; d.shift = 1'b1; end
                8'h3E: begin d.code = 8'h49; d.shift = 1'b1; end
                8'h3F: begin d.code = 8'h4A; d.shift = 1'b1; end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    state_t     r_state;
    logic [7:0] r_code;
    logic       r_shift;
    logic [7:0] r_out_byte;
    logic       r_out_valid;
    logic       r_err;
    logic       r_alive;   // low during reset and cleared asynchronously; holds off in_ready until the first clock after release

    dec_t       w_dec;
    logic       w_accept;

    assign w_dec     = decode(in_ascii, capslock);
    assign in_ready  = r_alive && (r_state == IDLE);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != IDLE);
    assign out_byte  = r_out_byte;
    assign out_valid = r_out_valid;
    assign err       = r_err;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= IDLE;
            r_code      <= 8'h00;
            r_shift     <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_alive     <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_dec.ok) begin
                            // character and caps-lock are latched here; later input changes are ignored
                            r_code      <= w_dec.code;
                            r_shift     <= w_dec.shift;
                            r_out_valid <= 1'b1;
                            if (w_dec.shift) begin
                                r_state    <= SH_MK;
                                r_out_byte <= SC_SHIFT;
                            end else begin
                                r_state    <= KEY_MK;
                                r_out_byte <= w_dec.code;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    // out_valid is high in every non-idle state, so out_ready alone completes the handshake
                    if (out_ready) begin
                        case (r_state)
                            SH_MK: begin
                                r_state    <= KEY_MK;
                                r_out_byte <= r_code;
                            end
                            KEY_MK: begin
                                r_state    <= KEY_F0;
                                r_out_byte <= SC_BREAK;
                            end
                            KEY_F0: begin
                                r_state    <= KEY_BRK;
                                r_out_byte <= r_code;
                            end
                            KEY_BRK: begin
                                if (r_shift) begin
                                    r_state    <= SH_F0;
                                    r_out_byte <= SC_BREAK;
                                end else begin
                                    r_state     <= IDLE;
                                    r_out_byte  <= 8'h00;
                                    r_out_valid <= 1'b0;
                                end
                            end
                            SH_F0: begin
                                r_state    <= SH_BRK;
                                r_out_byte <= SC_SHIFT;
                            end
                            default: begin
                                r_state     <= IDLE;
                                r_out_byte  <= 8'h00;
                                r_out_valid <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
